fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined CPU; sits directly upstream of decode and consumes the decode-stage stall produced by the register-hazard stall control.
- Owns the PC and drives a req/ack instruction-memory handshake.
- Presents one instruction per cycle to decode through an output register backed by a one-entry skid buffer.
- Execute-stage branch redirect flushes all fetched-but-unissued instructions.

Parameters:
ADDR_W, 16, PC / instruction-memory address width
INSTR_W, 16, instruction width
RESET_PC, 0, PC value after reset
PC_INC, 1, PC increment per fetched instruction (word addressing)

Ports:
i_clk  in  1  clock; single clock domain
i_reset  in  1  reset, synchronous, active-high
i_stall  in  1  decode stall; output held while high
i_branch_taken  in  1  one-cycle redirect pulse from execute
i_branch_target  in  ADDR_W  redirect PC, valid with i_branch_taken
o_imem_req  out  1  fetch request, registered
o_imem_addr  out  ADDR_W  fetch address, registered, stable while o_imem_req high
i_imem_ack  in  1  request complete; only meaningful while o_imem_req high; may assert in the same cycle req is first seen
i_imem_data  in  INSTR_W  instruction, valid with i_imem_ack
o_decode_valid  out  1  instruction presented to decode
o_decode_instr  out  INSTR_W  instruction to decode
o_decode_pc  out  ADDR_W  PC of o_decode_instr

Behaviour:
- Reset: o_imem_req=0, o_imem_addr=0, pc=RESET_PC, o_decode_valid=0, o_decode_instr=NOP, o_decode_pc=0, skid empty, state IDLE. Reset mid-transaction abandons the outstanding request; a late ack while req=0 is ignored.
- Consume: decode takes the output when o_decode_valid && !i_stall.
- While o_decode_valid && i_stall, all o_decode_* outputs hold.
- FSM states:
  - IDLE: req=0.
  - BUSY: req=1; result is kept.
  - DISCARD: req=1; result is dropped.
- IDLE:
  - Go to BUSY next cycle with o_imem_addr=pc when the skid is empty at end of cycle.
  - Redirect in IDLE: pc<=target; the next request uses the target.
  - First request is asserted the cycle after reset deasserts.
- BUSY, ack, no redirect:
  - pc<=pc+PC_INC.
  - If output is empty or being consumed, data and PC load the output register; stay BUSY with addr=pc+PC_INC (back-to-back, 1 instr/cycle with a zero-wait memory).
  - Otherwise data goes to the skid; go to IDLE.
- BUSY, redirect, no ack: pc<=target; go to DISCARD; o_imem_addr unchanged.
- BUSY, ack and redirect in the same cycle: data dropped; pc<=target; stay BUSY with addr=target.
- DISCARD:
  - On ack: data dropped; go to BUSY with addr=pc.
  - Further redirects update pc; stay in DISCARD.
- Redirect in any state:
  - Clears o_decode_valid and the skid the same edge.
  - Overrides i_stall: flush wins.
  - o_decode_instr returns to NOP.
- Output refill order on consume: skid first, then this-cycle ack data, else valid<=0.
- Skid empties when its entry moves to output.
- Ordering: instructions reach decode in fetch order; no duplicates and no drops except on redirect.
- PC arithmetic is modulo 2^ADDR_W; wrap from all-ones to 0 is silent.
- Occupancy never exceeds output+skid+one in-flight; a request is only issued with the skid empty.

Decomposition:
- cpu_pkg:
  - ADDR_W/INSTR_W defaults
  - NOP encoding
  - fetch_state_t enum {IDLE, BUSY, DISCARD}
  - fetch-packet struct {instr, pc}
- One sub-module: fetch_skid_buffer, a one-entry packet holding register with load/unload/flush.
- FSM, PC and imem handshake stay in fetch_stage.

Test Plan:
1. Zero-wait memory (ack same cycle as req) returning data=addr+0x100, no stall → after reset, req=1 one cycle after release; decode sees pc 0,1,2,3 on consecutive cycles with instr 0x100,0x101,0x102,0x103.
2. Stall raised for 3 cycles while pc=2 is presented → o_decode_pc stays 2, the skid captures pc 3, req drops to 0; on release decode sees 3,4 with no gap or duplicate.
3. Memory with 2-cycle ack latency, redirect to 0x40 one cycle into the fetch of pc 5 → o_imem_addr stays 5 until ack; that data is never presented; next req addr=0x40; decode's next pc is 0x40.
4. Redirect to 0x80 coincident with ack and with i_stall=1 and skid full → o_decode_valid=0 the next cycle, skid empty, next request addr=0x80.
5. RESET_PC=0xFFFE with zero-wait memory → decode sees pc 0xFFFE, 0xFFFF, 0x0000.
6. i_reset asserted while req=1 and ack pending, then ack pulsed while in reset → all outputs at reset values; the ack is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: default datapath widths, NOP encoding, fetch FSM states, fetch packet.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    // Bubble presented to decode while the output register holds nothing real.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'hA000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry packet holding register that catches a fetch result when decode is stalled.
// Latency: loaded packet is visible the cycle after i_load.
// Backpressure: caller loads only when empty; flush beats load beats unload.
module fetch_skid_buffer #(
    parameter int PKT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [PKT_W-1:0] i_pkt,
    input  logic             i_unload,
    input  logic             i_flush,
    output logic             o_vld,
    output logic [PKT_W-1:0] o_pkt
);

    logic             vld_q;
    logic             vld_d;
    logic [PKT_W-1:0] pkt_q;
    logic [PKT_W-1:0] pkt_d;

    // Next occupancy and payload: a flush always empties, a load always fills.
    always_comb begin
        vld_d = vld_q;
        pkt_d = pkt_q;
        if (i_flush) begin
            vld_d = 1'b0;
        end else if (i_load) begin
            vld_d = 1'b1;
            pkt_d = i_pkt;
        end else if (i_unload) begin
            vld_d = 1'b0;
        end
    end

    // Entry register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_q <= 1'b0;
            pkt_q <= '0;
        end else begin
            vld_q <= vld_d;
            pkt_q <= pkt_d;
        end
    end

    assign o_vld = vld_q;
    assign o_pkt = pkt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem req/ack, feeds decode through an output reg + skid.
// Latency: first req one cycle after reset; ack data reaches decode the edge after ack (1 instr/cycle at zero wait).
// Backpressure: i_stall holds decode outputs; a full skid stops new requests until it drains.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_stall,
    input  logic               i_branch_taken,
    input  logic [ADDR_W-1:0]  i_branch_target,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic               o_decode_valid,
    output logic [INSTR_W-1:0] o_decode_instr,
    output logic [ADDR_W-1:0]  o_decode_pc
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } pkt_t;

    localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);
    localparam logic [ADDR_W-1:0]  INC_W = ADDR_W'(PC_INC);

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic               imem_req_q;
    logic               imem_req_d;
    logic [ADDR_W-1:0]  imem_addr_q;
    logic [ADDR_W-1:0]  imem_addr_d;
    logic               dec_vld_q;
    logic               dec_vld_d;
    logic [INSTR_W-1:0] dec_instr_q;
    logic [INSTR_W-1:0] dec_instr_d;
    logic [ADDR_W-1:0]  dec_pc_q;
    logic [ADDR_W-1:0]  dec_pc_d;

    logic               ack;
    logic               consume;
    logic               out_free;
    logic               keep_ack;
    logic               ack_to_out;
    logic               ack_to_skid;
    logic               skid_unload;
    logic               skid_empty_next;
    logic [ADDR_W-1:0]  pc_inc;
    pkt_t               ack_pkt;
    logic               skid_vld;
    pkt_t               skid_pkt;

    // Handshake qualifiers: an ack only counts while a request is actually outstanding.
    always_comb begin
        ack             = imem_req_q && i_imem_ack;
        consume         = dec_vld_q && !i_stall;
        out_free        = !dec_vld_q || consume;
        pc_inc          = pc_q + INC_W;
        ack_pkt.instr   = i_imem_data;
        ack_pkt.pc      = pc_q;
        skid_unload     = consume && skid_vld;
        skid_empty_next = i_branch_taken || !skid_vld || consume;
    end

    // Fetch FSM: next state, PC and request/address; BUSY keeps ack data, DISCARD drops it.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        keep_ack    = 1'b0;
        ack_to_out  = 1'b0;
        ack_to_skid = 1'b0;
        case (state_q)
            IDLE: begin
                imem_req_d = 1'b0;
                if (i_branch_taken) begin
                    pc_d = i_branch_target;
                end
                // Only issue when the result is guaranteed a home.
                if (skid_empty_next) begin
                    state_d     = BUSY;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_d;
                end
            end
            BUSY: begin
                if (ack && i_branch_taken) begin
                    // Result belongs to the wrong path; restart at the target immediately.
                    pc_d        = i_branch_target;
                    imem_addr_d = i_branch_target;
                end else if (ack) begin
                    keep_ack = 1'b1;
                    pc_d     = pc_inc;
                    if (out_free && !skid_vld) begin
                        ack_to_out  = 1'b1;
                        imem_addr_d = pc_inc;
                    end else begin
                        ack_to_skid = 1'b1;
                        state_d     = IDLE;
                        imem_req_d  = 1'b0;
                    end
                end else if (i_branch_taken) begin
                    // Request is still in flight; address must stay stable until its ack.
                    pc_d    = i_branch_target;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (i_branch_taken) begin
                    pc_d = i_branch_target;
                end
                if (ack) begin
                    state_d     = BUSY;
                    imem_addr_d = pc_d;
                end
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // Decode output register: flush wins, then skid, then this cycle's ack, else bubble.
    always_comb begin
        dec_vld_d   = dec_vld_q;
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;
        if (i_branch_taken) begin
            dec_vld_d   = 1'b0;
            dec_instr_d = NOP_W;
        end else if (out_free) begin
            if (skid_vld) begin
                dec_vld_d   = 1'b1;
                dec_instr_d = skid_pkt.instr;
                dec_pc_d    = skid_pkt.pc;
            end else if (keep_ack && ack_to_out) begin
                dec_vld_d   = 1'b1;
                dec_instr_d = ack_pkt.instr;
                dec_pc_d    = ack_pkt.pc;
            end else begin
                dec_vld_d = 1'b0;
            end
        end
    end

    fetch_skid_buffer #(
        .PKT_W (INSTR_W + ADDR_W)
    ) u_skid (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (ack_to_skid),
        .i_pkt    (ack_pkt),
        .i_unload (skid_unload),
        .i_flush  (i_branch_taken),
        .o_vld    (skid_vld),
        .o_pkt    (skid_pkt)
    );

    // State, PC, request and decode-output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            dec_vld_q   <= 1'b0;
            dec_instr_q <= NOP_W;
            dec_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            dec_vld_q   <= dec_vld_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
        end
    end

    assign o_imem_req     = imem_req_q;
    assign o_imem_addr    = imem_addr_q;
    assign o_decode_valid = dec_vld_q;
    assign o_decode_instr = dec_instr_q;
    assign o_decode_pc    = dec_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: scoreboard of expected decode packets plus directed timing checks.
// Latency: memory model acks lat cycles after a request is first seen (lat=0 is zero-wait).
// Backpressure: i_stall driven directly by the stimulus.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] br_tgt;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic        ack_force;
    logic [15:0] imem_data;
    logic        dv;
    logic [15:0] dinstr;
    logic [15:0] dpc;

    logic        stall2;
    logic        req2;
    logic [15:0] addr2;
    logic        ack2;
    logic [15:0] imem_data2;
    logic        dv2;
    logic [15:0] dinstr2;
    logic [15:0] dpc2;

    int          lat;
    int          cnt;
    int          tests = 0;
    int          fails = 0;
    fetch_pkt_t  exp_q[$];

    fetch_stage dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_stall         (stall),
        .i_branch_taken  (br),
        .i_branch_target (br_tgt),
        .o_imem_req      (req),
        .o_imem_addr     (addr),
        .i_imem_ack      (ack),
        .i_imem_data     (imem_data),
        .o_decode_valid  (dv),
        .o_decode_instr  (dinstr),
        .o_decode_pc     (dpc)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut2 (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_stall         (stall2),
        .i_branch_taken  (1'b0),
        .i_branch_target (16'h0000),
        .o_imem_req      (req2),
        .o_imem_addr     (addr2),
        .i_imem_ack      (ack2),
        .i_imem_data     (imem_data2),
        .o_decode_valid  (dv2),
        .o_decode_instr  (dinstr2),
        .o_decode_pc     (dpc2)
    );

    // Memory models: data = addr + 0x100.
    always_comb begin
        ack        = ack_force | (req && (cnt >= lat));
        imem_data  = addr + 16'h0100;
        ack2       = req2;
        imem_data2 = addr2 + 16'h0100;
    end

    always_ff @(posedge clk) begin
        if (rst || !req || ack) cnt <= 0;
        else                    cnt <= cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every consumed decode packet must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && dv && !stall && !br) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got pc %h instr %h, expected no packet", dpc, dinstr);
            end else begin
                fetch_pkt_t e;
                e = exp_q.pop_front();
                check("sb_pc", 32'(dpc), 32'(e.pc));
                check("sb_instr", 32'(dinstr), 32'(e.instr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] pc);
        fetch_pkt_t p;
        p.pc    = pc;
        p.instr = pc + 16'h0100;
        exp_q.push_back(p);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) tick();
        exp_q.delete();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain_left", 32'(exp_q.size()), 32'd0);
        stall = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(req),    32'd0);
        check({tag, "_addr"},  32'(addr),   32'd0);
        check({tag, "_vld"},   32'(dv),     32'd0);
        check({tag, "_instr"}, 32'(dinstr), 32'(NOP_INSTR));
        check({tag, "_pc"},    32'(dpc),    32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; stall2 = 1'b1; br = 1'b0; br_tgt = '0;
        ack_force = 1'b0; lat = 0;
        apply_reset();
        check_reset_outputs("rst");

        // Zero-wait streaming, then a 3-cycle stall while pc 2 is presented.
        for (int p = 0; p < 8; p++) push(16'(p));
        rst = 1'b0;
        check("t1_req_before", 32'(req), 32'd0);
        tick();
        check("t1_req_first", 32'(req), 32'd1);
        check("t1_addr_first", 32'(addr), 32'd0);
        for (int p = 0; p < 3; p++) begin
            tick();
            check("t1_vld", 32'(dv), 32'd1);
            check("t1_pc", 32'(dpc), 32'(p));
            check("t1_instr", 32'(dinstr), 32'(p + 16'h100));
        end
        stall = 1'b1;
        check("t2_addr3", 32'(addr), 32'd3);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("t2_hold_pc", 32'(dpc), 32'd2);
            check("t2_hold_vld", 32'(dv), 32'd1);
            check("t2_req_drop", 32'(req), 32'd0);
        end
        tick();
        stall = 1'b0;
        check("t2_rel_pc", 32'(dpc), 32'd2);
        tick();
        check("t2_next_pc3", 32'(dpc), 32'd3);
        check("t2_next_vld", 32'(dv), 32'd1);
        tick();
        check("t2_next_pc4", 32'(dpc), 32'd4);
        drain(40);

        // 2-cycle memory, redirect to 0x40 while pc 5 is outstanding.
        lat = 2;
        apply_reset();
        for (int p = 0; p < 5; p++) push(16'(p));
        for (int p = 0; p < 3; p++) push(16'(16'h40 + p));
        stall = 1'b0;
        rst = 1'b0;
        begin
            bit found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                tick();
                if (req && addr == 16'd5) found = 1'b1;
            end
            check("t3_saw_addr5", 32'(found), 32'd1);
        end
        tick();
        br = 1'b1; br_tgt = 16'h0040;
        tick();
        br = 1'b0;
        check("t3_addr_hold", 32'(addr), 32'd5);
        check("t3_req_hold", 32'(req), 32'd1);
        check("t3_vld", 32'(dv), 32'd0);
        tick();
        check("t3_addr_tgt", 32'(addr), 32'h40);
        check("t3_req_tgt", 32'(req), 32'd1);
        drain(60);

        // Redirect with stall held, skid full, and a stray ack while req is low.
        lat = 0;
        apply_reset();
        push(16'd0); push(16'd1);
        for (int p = 0; p < 3; p++) push(16'(16'h80 + p));
        stall = 1'b0;
        rst = 1'b0;
        begin
            bit found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                tick();
                if (dv && dpc == 16'd2) found = 1'b1;
            end
            check("t4_saw_pc2", 32'(found), 32'd1);
        end
        stall = 1'b1;
        tick();
        tick();
        check("t4_req_low", 32'(req), 32'd0);
        br = 1'b1; br_tgt = 16'h0080; ack_force = 1'b1;
        tick();
        br = 1'b0; ack_force = 1'b0;
        check("t4_vld_flushed", 32'(dv), 32'd0);
        check("t4_instr_nop", 32'(dinstr), 32'(NOP_INSTR));
        check("t4_req", 32'(req), 32'd1);
        check("t4_addr", 32'(addr), 32'h80);
        stall = 1'b0;
        tick();
        check("t4_first_pc", 32'(dpc), 32'h80);
        check("t4_first_instr", 32'(dinstr), 32'h180);
        drain(40);

        // PC wrap on the second instance.
        stall = 1'b1;
        apply_reset();
        stall2 = 1'b0;
        rst = 1'b0;
        tick();
        check("t5_req", 32'(req2), 32'd1);
        check("t5_addr", 32'(addr2), 32'hFFFE);
        tick();
        check("t5_pc0", 32'(dpc2), 32'hFFFE);
        check("t5_instr0", 32'(dinstr2), 32'h00FE);
        tick();
        check("t5_pc1", 32'(dpc2), 32'hFFFF);
        check("t5_instr1", 32'(dinstr2), 32'h00FF);
        tick();
        check("t5_pc2", 32'(dpc2), 32'h0000);
        check("t5_instr2", 32'(dinstr2), 32'h0100);
        check("t5_vld2", 32'(dv2), 32'd1);
        stall2 = 1'b1;

        // Reset during an outstanding request, acks during and after reset ignored.
        lat = 2;
        apply_reset();
        stall = 1'b0;
        rst = 1'b0;
        tick();
        check("t6_req", 32'(req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        ack_force = 1'b1;
        check_reset_outputs("t6_rst");
        tick();
        ack_force = 1'b0;
        check_reset_outputs("t6_rst2");
        exp_q.delete();
        push(16'd0); push(16'd1); push(16'd2);
        rst = 1'b0;
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        check("t6_restart_req", 32'(req), 32'd1);
        check("t6_restart_addr", 32'(addr), 32'd0);
        check("t6_restart_vld", 32'(dv), 32'd0);
        drain(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
